// File: rtl/mul_iter_q16_if.sv
// rtl/mul_iter_q16_if.sv - start/valid/busy compute handshake bundle for mul_iter_q16
interface mul_iter_q16_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             valid;
  logic             busy;
  logic             ovf;

  modport master (
    output start, a, b,
    input  result, valid, busy, ovf
  );

  modport slave (
    input  start, a, b,
    output result, valid, busy, ovf
  );
endinterface

// File: rtl/mul_iter_q16.sv
// rtl/mul_iter_q16.sv - iterative radix-2 signed Q-format multiplier with saturation
module mul_iter_q16 #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic         clk,
  input  logic         reset,
  mul_iter_q16_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW    = 2 * WIDTH + 1;

  // Saturation bounds expressed in the wide signed product domain.
  localparam logic signed [PW-1:0] MAX_Q = {{(WIDTH + 2){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_Q = {{(WIDTH + 2){1'b1}}, {(WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_NORM = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 sign_q, sign_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 ovf_q, ovf_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic signed [PW-1:0] prod_s, quo_s;

  // Operand magnitudes and signed normalisation of the unsigned accumulator.
  always_comb begin
    mag_a  = bus.a[WIDTH-1] ? (~bus.a + WIDTH'(1)) : bus.a;
    mag_b  = bus.b[WIDTH-1] ? (~bus.b + WIDTH'(1)) : bus.b;
    prod_s = signed'({1'b0, acc_q});
    if (sign_q) begin
      prod_s = -prod_s;
    end
    quo_s  = prod_s >>> FRAC;
  end

  // Next-state logic: accept, shift-add one multiplier bit per cycle, then saturate.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    sign_d   = sign_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d  = S_MUL;
          busy_d   = 1'b1;
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          acc_d    = '0;
          sign_d   = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
          cnt_d    = '0;
        end else begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
        end
      end
      S_MUL: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (quo_s > MAX_Q) begin
          result_d = {1'b0, {(WIDTH - 1){1'b1}}};
          ovf_d    = 1'b1;
        end else if (quo_s < MIN_Q) begin
          result_d = {1'b1, {(WIDTH - 1){1'b0}}};
          ovf_d    = 1'b1;
        end else begin
          result_d = quo_s[WIDTH-1:0];
          ovf_d    = 1'b0;
        end
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; async reset aborts any op in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      sign_q   <= sign_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.result = result_q;
  assign bus.ovf    = ovf_q;
  assign bus.valid  = valid_q;
  assign bus.busy   = busy_q;

endmodule
